// File: rtl/ctrl_pkg.sv
// Shared opcode, FSM-state and control-word definitions for the opcode -> controlUnit interface.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } issueState_t;

  // Bit positions inside the 9-bit control word, identical to controlUnit's outCode packing.
  localparam int CW_REGDST   = 8;
  localparam int CW_ALUSRC   = 7;
  localparam int CW_MEMTOREG = 6;
  localparam int CW_REGWRITE = 5;
  localparam int CW_MEMREAD  = 4;
  localparam int CW_MEMWRITE = 3;
  localparam int CW_BRANCH   = 2;
  localparam int CW_ALUOP1   = 1;
  localparam int CW_ALUOP0   = 0;

  function automatic logic isLegalOp(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue: DEPTH x WIDTH FIFO; a push while full is accepted only alongside a pop.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wrData,
  output logic [WIDTH-1:0]         rdData,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             full;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/opcode_issue_unit.sv
// Queues fetched instructions, issues opcodes to controlUnit, and holds the returned
// control word for the datapath for an opcode-dependent number of cycles.
module opcode_issue_unit
  import ctrl_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int CU_LATENCY = 1,
  parameter int LW_CYCLES  = 3,
  parameter int SW_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [5:0]  inCode,
  input  logic [8:0]  outCode,
  output logic [8:0]  ctrl_word,
  output logic        ctrl_valid,
  output logic        illegal,
  output logic [15:0] issued_cnt
);

  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int LAT_W    = $clog2(CU_LATENCY + 1);
  localparam int HOLD_MAX = (LW_CYCLES > SW_CYCLES) ? LW_CYCLES : SW_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(CU_LATENCY);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  issueState_t       state;
  logic [LAT_W-1:0]  latCnt;
  logic [HOLD_W-1:0] holdCnt;
  logic [31:0]       headInstr;
  logic [5:0]        headOp;
  logic              queueEmpty;
  logic [CNT_W-1:0]  queueCount;
  logic              queuePop;
  logic              holdLast;
  logic              unusedOperands;

  function automatic logic [HOLD_W-1:0] holdLoad(input logic [5:0] op);
    case (op)
      OP_LW:   return HOLD_W'(LW_CYCLES);
      OP_SW:   return HOLD_W'(SW_CYCLES);
      default: return HOLD_ONE;
    endcase
  endfunction

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_instr_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (instr_valid),
    .pop    (queuePop),
    .wrData (instr_in),
    .rdData (headInstr),
    .empty  (queueEmpty),
    .count  (queueCount)
  );

  // Only the opcode is issued here; operand fields travel to the datapath by another path.
  assign headOp         = headInstr[31:26];
  assign unusedOperands = ^headInstr[25:0];

  assign instr_ready = (queueCount != FULL_CNT);
  assign holdLast    = (state == ST_HOLD) && (holdCnt == HOLD_ONE);
  assign queuePop    = ~queueEmpty && ((state == ST_IDLE) || holdLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      inCode     <= OP_RTYPE;
      latCnt     <= '0;
      holdCnt    <= '0;
      ctrl_word  <= '0;
      ctrl_valid <= 1'b0;
      illegal    <= 1'b0;
      issued_cnt <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!queueEmpty) begin
            inCode <= headOp;
            latCnt <= LAT_INIT;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (latCnt == '0) begin
            if (isLegalOp(inCode)) begin
              ctrl_word  <= outCode;
              ctrl_valid <= 1'b1;
              holdCnt    <= holdLoad(inCode);
              state      <= ST_HOLD;
            end else begin
              ctrl_word <= '0;
              illegal   <= 1'b1;
              state     <= ST_IDLE;
            end
          end else begin
            latCnt <= latCnt - LAT_ONE;
          end
        end
        ST_HOLD: begin
          if (holdCnt == HOLD_ONE) begin
            ctrl_valid <= 1'b0;
            issued_cnt <= issued_cnt + 16'd1;
            // Back-to-back issue: the next opcode goes out on the edge ctrl_valid drops.
            if (!queueEmpty) begin
              inCode <= headOp;
              latCnt <= LAT_INIT;
              state  <= ST_WAIT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            holdCnt <= holdCnt - HOLD_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opcode_issue_unit.sv
// Directed bench for opcode_issue_unit with a one-cycle-latency controlUnit model.
module tb_opcode_issue_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  inCode;
  logic [8:0]  outCode;
  logic [8:0]  ctrl_word;
  logic        ctrl_valid;
  logic        illegal;
  logic [15:0] issued_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] I_RTYPE   = 32'h00221820;
  localparam logic [31:0] I_SW      = 32'hAC220004;
  localparam logic [31:0] I_LW      = 32'h8C220004;
  localparam logic [31:0] I_BEQ     = 32'h10220004;
  localparam logic [31:0] I_ILLEGAL = 32'hFC000000;

  // Control words, field order RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp[1:0].
  localparam logic [8:0] CW_R   = 9'b100100010;
  localparam logic [8:0] CW_LW  = 9'b011110000;
  localparam logic [8:0] CW_SW  = 9'b010001000;
  localparam logic [8:0] CW_BEQ = 9'b000000101;

  opcode_issue_unit #(
    .DEPTH      (4),
    .CU_LATENCY (1),
    .LW_CYCLES  (3),
    .SW_CYCLES  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .inCode      (inCode),
    .outCode     (outCode),
    .ctrl_word   (ctrl_word),
    .ctrl_valid  (ctrl_valid),
    .illegal     (illegal),
    .issued_cnt  (issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] cuDecode(input logic [5:0] op);
    case (op)
      6'b000000: return CW_R;
      6'b100011: return CW_LW;
      6'b101011: return CW_SW;
      6'b000100: return CW_BEQ;
      default:   return 9'b0;
    endcase
  endfunction

  always_ff @(posedge clk) outCode <= cuDecode(inCode);

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    instr_in    = I_RTYPE;

    // Reset with instr_valid high: nothing may be queued
    tick(1);
    check("rst1_valid",  32'(ctrl_valid),  32'd0);
    check("rst1_incode", 32'(inCode),      32'd0);
    check("rst1_ready",  32'(instr_ready), 32'd1);
    tick(1);
    check("rst2_valid",   32'(ctrl_valid), 32'd0);
    check("rst2_word",    32'(ctrl_word),  32'd0);
    check("rst2_illegal", 32'(illegal),    32'd0);
    check("rst2_issued",  32'(issued_cnt), 32'd0);
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    tick(3);
    check("post_rst_valid", 32'(ctrl_valid), 32'd0);
    tick(1);
    check("post_rst_issued", 32'(issued_cnt), 32'd0);
    check("post_rst_ready",  32'(instr_ready), 32'd1);

    // Single R-type: push at N, inCode at N+1, ctrl_valid N+3 for one cycle
    instr_valid = 1'b1;
    instr_in    = I_RTYPE;
    tick(1);
    instr_valid = 1'b0;
    tick(2);
    check("r_wait_valid", 32'(ctrl_valid), 32'd0);
    tick(1);
    check("r_valid",  32'(ctrl_valid), 32'd1);
    check("r_word",   32'(ctrl_word),  32'(CW_R));
    check("r_incode", 32'(inCode),     32'd0);
    tick(1);
    check("r_drop",   32'(ctrl_valid), 32'd0);
    check("r_issued", 32'(issued_cnt), 32'd1);

    // sw then lw back-to-back
    instr_valid = 1'b1;
    instr_in    = I_SW;
    tick(1);
    instr_in    = I_LW;
    tick(1);
    instr_valid = 1'b0;
    check("sw_incode", 32'(inCode), 32'h2B);
    tick(2);
    check("sw_valid1", 32'(ctrl_valid), 32'd1);
    check("sw_word",   32'(ctrl_word),  32'(CW_SW));
    tick(1);
    check("sw_valid2", 32'(ctrl_valid), 32'd1);
    tick(1);
    check("sw_drop",   32'(ctrl_valid), 32'd0);
    check("lw_incode", 32'(inCode),     32'h23);
    check("sw_issued", 32'(issued_cnt), 32'd2);
    tick(1);
    check("lw_wait_valid", 32'(ctrl_valid), 32'd0);
    tick(1);
    check("lw_valid1", 32'(ctrl_valid), 32'd1);
    check("lw_word",   32'(ctrl_word),  32'(CW_LW));
    tick(2);
    check("lw_valid3", 32'(ctrl_valid), 32'd1);
    tick(1);
    check("lw_drop",   32'(ctrl_valid), 32'd0);
    check("lw_issued", 32'(issued_cnt), 32'd3);

    // Illegal opcode followed by beq
    instr_valid = 1'b1;
    instr_in    = I_ILLEGAL;
    tick(1);
    instr_in    = I_BEQ;
    tick(1);
    instr_valid = 1'b0;
    check("ill_incode", 32'(inCode), 32'h3F);
    tick(1);
    check("ill_early", 32'(illegal), 32'd0);
    tick(1);
    check("ill_pulse", 32'(illegal),    32'd1);
    check("ill_valid", 32'(ctrl_valid), 32'd0);
    check("ill_word",  32'(ctrl_word),  32'd0);
    tick(1);
    check("ill_end",     32'(illegal),    32'd0);
    check("ill_valid2",  32'(ctrl_valid), 32'd0);
    check("ill_issued",  32'(issued_cnt), 32'd3);
    check("beq_incode",  32'(inCode),     32'h04);
    tick(2);
    check("beq_valid", 32'(ctrl_valid), 32'd1);
    check("beq_word",  32'(ctrl_word),  32'(CW_BEQ));
    tick(1);
    check("beq_issued", 32'(issued_cnt), 32'd4);

    // Fill: 7 lw offered on consecutive edges; the 6th is dropped (full), the 7th meets a pop
    instr_valid = 1'b1;
    instr_in    = I_LW;
    tick(4);
    check("fill_ready_f4", 32'(instr_ready), 32'd1);
    tick(1);
    check("fill_ready_f5", 32'(instr_ready), 32'd0);
    tick(1);
    check("fill_ready_f6", 32'(instr_ready), 32'd0);
    tick(1);
    instr_valid = 1'b0;
    check("fill_ready_f7",  32'(instr_ready), 32'd0);
    check("fill_issued_f7", 32'(issued_cnt),  32'd5);
    tick(4);
    check("fill_ready_f11", 32'(instr_ready), 32'd0);
    tick(1);
    check("fill_ready_f12",  32'(instr_ready), 32'd1);
    check("fill_issued_f12", 32'(issued_cnt),  32'd6);
    tick(19);
    check("fill_issued_f31", 32'(issued_cnt), 32'd9);
    tick(1);
    check("fill_issued_f32", 32'(issued_cnt), 32'd10);
    check("fill_valid_f32",  32'(ctrl_valid), 32'd0);
    tick(8);
    check("fill_settled_issued", 32'(issued_cnt), 32'd10);
    check("fill_settled_valid",  32'(ctrl_valid), 32'd0);

    // Reset during lw HOLD with more work still queued
    instr_valid = 1'b1;
    instr_in    = I_LW;
    tick(3);
    instr_valid = 1'b0;
    tick(1);
    check("mid_hold_valid", 32'(ctrl_valid), 32'd1);
    check("mid_hold_word",  32'(ctrl_word),  32'(CW_LW));
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_valid",  32'(ctrl_valid),  32'd0);
    check("mid_rst_issued", 32'(issued_cnt),  32'd0);
    check("mid_rst_ready",  32'(instr_ready), 32'd1);
    check("mid_rst_incode", 32'(inCode),      32'd0);
    rst_n = 1'b1;
    tick(4);
    check("after_rst_incode", 32'(inCode),     32'd0);
    check("after_rst_valid",  32'(ctrl_valid), 32'd0);
    check("after_rst_issued", 32'(issued_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
